// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multicycle controller.
//   state_t  : FSM state enumeration (TRAP exists only with MC_ILLEGAL_TRAP_EN)
//   ctrl_t   : datapath control word produced by mc_outdec
//   opcodes  : RTYPE, LW, SW, BEQ, ADDI, J
//   selects  : ALU class (aluop), ALU B operand (alusrcb), PC source (pcsrc)
// Configuration macro: MC_ILLEGAL_TRAP_EN
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEXEC,
    ADDIWB,
    JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  // Opcodes
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  // ALU decoder class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec -- combinational state-to-control-word decode.
// Ports:
//   i_state     : current FSM state
//   i_mem_ready : memory completes the access this cycle (qualifies fetch writes)
//   i_rst_n     : active-low reset; forces all write enables low while asserted
//   o_ctrl      : control strobes and mux selects
//   o_illegal   : high in TRAP (constant 0 without MC_ILLEGAL_TRAP_EN)
// Configuration macro: MC_ILLEGAL_TRAP_EN
module mc_outdec
  import mc_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_rst_n,
  output ctrl_t  o_ctrl,
  output logic   o_illegal
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (i_state)
      FETCH: begin
        w_ctrl.iord    = 1'b0;
        w_ctrl.alusrca = 1'b0;
        w_ctrl.alusrcb = SRCB_FOUR;
        w_ctrl.aluop   = ALUOP_ADD;
        w_ctrl.pcsrc   = PC_ALURES;
        w_ctrl.irwrite = i_mem_ready;
        w_ctrl.pcwrite = i_mem_ready;
      end
      DECODE: begin
        w_ctrl.alusrca = 1'b0;
        w_ctrl.alusrcb = SRCB_IMMSH;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEXEC: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_IMM;
        w_ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        w_ctrl.iord = 1'b1;
      end
      MEMWB: begin
        w_ctrl.regdst   = 1'b0;
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      MEMWR: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_REG;
        w_ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.memtoreg = 1'b0;
        w_ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        w_ctrl.alusrca = 1'b1;
        w_ctrl.alusrcb = SRCB_REG;
        w_ctrl.aluop   = ALUOP_SUB;
        w_ctrl.pcsrc   = PC_ALUOUT;
        w_ctrl.branch  = 1'b1;
      end
      ADDIWB: begin
        w_ctrl.regdst   = 1'b0;
        w_ctrl.memtoreg = 1'b0;
        w_ctrl.regwrite = 1'b1;
      end
      JUMP: begin
        w_ctrl.pcsrc   = PC_JUMP;
        w_ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase

    // Reset parks the state in FETCH, whose strobes follow mem_ready, so the
    // write enables are squashed here rather than relying on the state alone.
    o_ctrl = w_ctrl;
    if (!i_rst_n) begin
      o_ctrl.pcwrite  = 1'b0;
      o_ctrl.irwrite  = 1'b0;
      o_ctrl.memwrite = 1'b0;
      o_ctrl.regwrite = 1'b0;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign o_illegal = (i_state == TRAP);
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/mc_controller.sv
// mc_controller -- multicycle CPU control FSM with retired-instruction counter.
// Ports:
//   clk, reset_n      : clock (rising edge) and asynchronous active-low reset
//   op                : IR opcode, sampled in DECODE and MEMADR only
//   mem_ready         : memory completes the current access this cycle
//   pcwrite..memtoreg : 1-bit datapath strobes / selects
//   alusrcb, pcsrc, aluop : 2-bit selects
//   instr_count       : retired instructions, wraps modulo 2^CNT_W
//   illegal           : illegal opcode trapped (MC_ILLEGAL_TRAP_EN only)
// Configuration macro: MC_ILLEGAL_TRAP_EN -- illegal opcodes trap instead of
// retiring as NOPs.
module mc_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             branch,
  output logic             iord,
  output logic             alusrca,
  output logic             regdst,
  output logic             memtoreg,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;
  ctrl_t            w_ctrl;
  logic             w_illegal;

  // Next state; w_retire marks the edge on which an instruction completes.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      FETCH: begin
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        case (op)
          RTYPE:   w_next = EXECUTE;
          LW, SW:  w_next = MEMADR;
          BEQ:     w_next = BRANCH;
          ADDI:    w_next = ADDIEXEC;
          J:       w_next = JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_next   = TRAP;
`else
            // Unknown opcode retires as a NOP straight from DECODE.
            w_next   = FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        w_next = (op == LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (mem_ready) w_next = MEMWB;
      end
      MEMWR: begin
        if (mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      EXECUTE:  w_next = ALUWB;
      ADDIEXEC: w_next = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: w_next = TRAP;
`endif
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  mc_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_rst_n     (reset_n),
    .o_ctrl      (w_ctrl),
    .o_illegal   (w_illegal)
  );

  assign pcwrite     = w_ctrl.pcwrite;
  assign irwrite     = w_ctrl.irwrite;
  assign memwrite    = w_ctrl.memwrite;
  assign regwrite    = w_ctrl.regwrite;
  assign branch      = w_ctrl.branch;
  assign iord        = w_ctrl.iord;
  assign alusrca     = w_ctrl.alusrca;
  assign regdst      = w_ctrl.regdst;
  assign memtoreg    = w_ctrl.memtoreg;
  assign alusrcb     = w_ctrl.alusrcb;
  assign pcsrc       = w_ctrl.pcsrc;
  assign aluop       = w_ctrl.aluop;
  assign instr_count = r_count;
  assign illegal     = w_illegal;

endmodule
